// File: rtl/puf_challenge_sequencer_pkg.sv
// Shared types and constants for the arbiter-PUF challenge sequencer.
package puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HIGH,
        ST_LOW,
        ST_DONE
    } state_e;

    // x^8+x^6+x^5+x^4+1 : feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] SEED_ZERO_SUB = 8'h01;

endpackage

// File: rtl/puf_challenge_sequencer_lfsr.sv
// Challenge register: loads a (non-zero) seed, advances as a left-shifting Fibonacci LFSR.
module puf_lfsr
    import puf_pkg::*;
#(
    parameter int CHAL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    input  logic [CHAL_W-1:0] seed,
    output logic [CHAL_W-1:0] challenge
);

    localparam logic [CHAL_W-1:0] TAPS     = CHAL_W'(LFSR_TAPS);
    localparam logic [CHAL_W-1:0] ZERO_SUB = CHAL_W'(SEED_ZERO_SUB);

    logic [CHAL_W-1:0] chal_q, chal_d;

    always_comb begin
        chal_d = chal_q;
        if (load) begin
            chal_d = (seed == '0) ? ZERO_SUB : seed;
        end else if (advance) begin
            chal_d = {chal_q[CHAL_W-2:0], ^(chal_q & TAPS)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chal_q <= '0;
        end else begin
            chal_q <= chal_d;
        end
    end

    assign challenge = chal_q;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Sequences arbiter-PUF evaluations: launch pulses, synchronised sampling,
// per-bit majority vote and a valid/ready response word.
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int CHAL_W = 8,
    parameter int RESP_W = 8,
    parameter int VOTES  = 7,
    parameter int SETTLE = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CHAL_W-1:0] seed,
    output logic [CHAL_W-1:0] challenge,
    output logic              puf_fire,
    input  logic              puf_resp,
    output logic [RESP_W-1:0] resp_word,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              busy
);

    localparam int VOTE_W = $clog2(VOTES + 1);
    localparam int BIT_W  = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int PH_W   = $clog2(SETTLE + 2);

    localparam logic [PH_W-1:0]   HIGH_LAST = PH_W'(SETTLE + 1);
    localparam logic [PH_W-1:0]   LOW_LAST  = PH_W'(SETTLE - 1);
    localparam logic [VOTE_W-1:0] VOTES_C   = VOTE_W'(VOTES);
    localparam logic [VOTE_W-1:0] HALF_C    = VOTE_W'(VOTES / 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(RESP_W - 1);

    state_e              state_q, state_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [VOTE_W-1:0]   vote_q, vote_d;
    logic [VOTE_W-1:0]   ones_q, ones_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [RESP_W-1:0]   word_q, word_d;
    logic                fire_q, fire_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                meta_q, sync_q;
    logic                lfsr_load, lfsr_advance;

    puf_lfsr #(
        .CHAL_W (CHAL_W)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (lfsr_load),
        .advance   (lfsr_advance),
        .seed      (seed),
        .challenge (challenge)
    );

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        vote_d       = vote_q;
        ones_d       = ones_q;
        bit_d        = bit_q;
        word_d       = word_q;
        lfsr_load    = 1'b0;
        lfsr_advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    phase_d   = '0;
                    vote_d    = '0;
                    ones_d    = '0;
                    bit_d     = '0;
                    word_d    = '0;
                    lfsr_load = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_HIGH;
                phase_d = '0;
            end
            ST_HIGH: begin
                // Arbiter has settled by the last HIGH cycle; take one vote.
                if (phase_q == HIGH_LAST) begin
                    ones_d  = ones_q + VOTE_W'(sync_q);
                    vote_d  = vote_q + 1'b1;
                    phase_d = '0;
                    state_d = ST_LOW;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_LOW: begin
                if (phase_q == LOW_LAST) begin
                    phase_d = '0;
                    if (vote_q < VOTES_C) begin
                        state_d = ST_HIGH;
                    end else begin
                        word_d[bit_q] = (ones_q > HALF_C);
                        vote_d        = '0;
                        ones_d        = '0;
                        lfsr_advance  = 1'b1;
                        if (bit_q < BIT_LAST) begin
                            bit_d   = bit_q + 1'b1;
                            state_d = ST_HIGH;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        fire_d  = (state_d == ST_HIGH);
        valid_d = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            vote_q  <= '0;
            ones_q  <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            fire_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            vote_q  <= vote_d;
            ones_q  <= ones_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            fire_q  <= fire_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            meta_q  <= puf_resp;
            sync_q  <= meta_q;
        end
    end

    assign puf_fire   = fire_q;
    assign resp_word  = word_q;
    assign resp_valid = valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench for puf_challenge_sequencer with a behavioural PUF stub and a pulse-shape monitor.
module tb_puf_challenge_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] seed;
    logic [7:0] challenge;
    logic       puf_fire;
    logic       puf_resp;
    logic [7:0] resp_word;
    logic       resp_valid;
    logic       resp_ready;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    int stub_mode  = 0;
    int vote_idx   = 0;
    int fire_rises = 0;
    int high_len   = 0;
    int low_len    = 0;
    bit low_track  = 0;
    logic       fire_prev = 1'b0;
    logic [7:0] chal_prev = 8'h00;
    logic [7:0] chal_hold;
    logic [7:0] exp_seq [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};

    puf_challenge_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .seed       (seed),
        .challenge  (challenge),
        .puf_fire   (puf_fire),
        .puf_resp   (puf_resp),
        .resp_word  (resp_word),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PUF stub: mode 0 echoes challenge[0]; modes 1/2 answer 1 on the first 4/3 votes of each bit.
    always_comb begin
        case (stub_mode)
            1:       puf_resp = (vote_idx < 4);
            2:       puf_resp = (vote_idx < 3);
            default: puf_resp = challenge[0];
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse-shape monitor: HIGH/LOW widths, challenge stability while firing, challenge per bit.
    always @(negedge clk) begin
        if (!rst_n || !busy) begin
            fire_rises = 0;
            high_len   = 0;
            low_len    = 0;
            low_track  = 0;
            fire_prev  = 1'b0;
        end else begin
            if (puf_fire && !fire_prev) begin
                if (low_track) check("low_width", low_len, 3);
                fire_rises++;
                vote_idx = (fire_rises - 1) % 7;
                if (vote_idx == 0 && (fire_rises - 1) / 7 < 8)
                    check("chal_seq", challenge, exp_seq[(fire_rises - 1) / 7]);
                high_len  = 1;
                low_track = 0;
            end else if (puf_fire && fire_prev) begin
                check("chal_stable_fire", challenge, chal_prev);
                high_len++;
            end else if (!puf_fire && fire_prev) begin
                check("high_width", high_len, 5);
                low_len   = 1;
                low_track = 1;
            end else begin
                low_len++;
            end
            if (resp_valid) low_track = 0;
            fire_prev = puf_fire;
        end
        chal_prev = challenge;
    end

    // Called #1 after a posedge; returns #1 after E0+449.
    task automatic start_word(input logic [7:0] s, input logic [7:0] exp_chal);
        seed  = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_E0", busy, 1);
        check("chal_E0", challenge, exp_chal);
        check("fire_in_load", puf_fire, 0);
        @(posedge clk); #1;
        check("fire_E0p1", puf_fire, 1);
        repeat (447) @(posedge clk);
        #1;
        check("valid_E0p448", resp_valid, 0);
        @(posedge clk); #1;
        check("valid_E0p449", resp_valid, 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        seed       = 8'h00;
        resp_ready = 1'b1;
        #12;
        check("rst_challenge", challenge, 0);
        check("rst_fire", puf_fire, 0);
        check("rst_word", resp_word, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 1: echo stub, seed 01
        stub_mode = 0;
        start_word(8'h01, 8'h01);
        check("t1_word", resp_word, 8'h71);
        @(posedge clk); #1;
        check("t1_valid_1cyc", resp_valid, 0);
        check("t1_busy_fall", busy, 0);

        // Test 2: seed 00 substitutes 01
        start_word(8'h00, 8'h01);
        check("t2_word", resp_word, 8'h71);
        @(posedge clk); #1;
        check("t2_valid_1cyc", resp_valid, 0);

        // Test 3: majority boundary 4-of-7 and 3-of-7
        stub_mode = 1;
        start_word(8'h01, 8'h01);
        check("t3_word_4of7", resp_word, 8'hFF);
        @(posedge clk); #1;
        stub_mode = 2;
        start_word(8'h01, 8'h01);
        check("t3_word_3of7", resp_word, 8'h00);
        @(posedge clk); #1;

        // Test 4: backpressure in DONE with start pulses
        stub_mode  = 0;
        resp_ready = 1'b0;
        start_word(8'h01, 8'h01);
        check("t4_word", resp_word, 8'h71);
        chal_hold = challenge;
        for (int i = 0; i < 20; i++) begin
            start = (i % 2 == 0);
            seed  = 8'h55;
            @(posedge clk); #1;
            check("t4_valid_held", resp_valid, 1);
            check("t4_word_held", resp_word, 8'h71);
            check("t4_busy_held", busy, 1);
            check("t4_chal_held", challenge, chal_hold);
        end
        start      = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_valid_drop", resp_valid, 0);
        check("t4_busy_drop", busy, 0);
        seed  = 8'h01;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("t4_restart_busy", busy, 1);
        check("t4_restart_chal", challenge, 8'h01);

        // Test 5: async reset while firing at vote 3 of bit 4
        begin
            int n = 0;
            while (!(fire_rises >= 32 && puf_fire) && n < 1000) begin
                @(posedge clk); #1;
                n++;
            end
            check("t5_reach_bit4_vote3", (fire_rises == 32 && puf_fire), 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_fire", puf_fire, 0);
        check("t5_rst_challenge", challenge, 0);
        check("t5_rst_word", resp_word, 0);
        check("t5_rst_valid", resp_valid, 0);
        check("t5_rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_word(8'h01, 8'h01);
        check("t5_word", resp_word, 8'h71);
        @(posedge clk); #1;
        check("t5_busy_fall", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/puf_challenge_sequencer.md
# puf_challenge_sequencer

Drives the arbiter-PUF delay line from the system clock domain and collects its single-bit output into a multi-bit response word.
- Generates each challenge from an 8-bit LFSR and issues a rising-edge launch pulse per evaluation.
- Samples the arbiter output through a synchronizer and majority-votes several evaluations per challenge bit.
- Presents the assembled word on a valid/ready handshake.

It sits directly upstream and downstream of the arbiter PUF instance: it feeds `ipulse` and `ichallenge`, and consumes `oresponse`.

## Interface
Parameters:
- `CHAL_W`, 8, challenge width; equals the delay-line mux-chain length.
- `RESP_W`, 8, number of response bits per word.
- `VOTES`, 7, evaluations per response bit; must be odd and at least 1.
- `SETTLE`, 3, settle cycles per phase; must be at least 1.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a new response word; accepted only when `busy`=0.
- `seed`  in  CHAL_W  initial LFSR value; 0 is replaced by 1.
- `challenge`  out  CHAL_W  to the PUF challenge input.
- `puf_fire`  out  1  to the PUF launch pulse input.
- `puf_resp`  in  1  from the PUF response; asynchronous to `clk`.
- `resp_word`  out  RESP_W  assembled response.
- `resp_valid`  out  1  `resp_word` is valid.
- `resp_ready`  in  1  consumer accepts the word.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, LOAD, HIGH, LOW, DONE.
- IDLE: when `start`=1, go to LOAD.
  - Set `challenge` <= `seed` (or 1 if `seed`=0).
  - Clear `resp_word`, the vote counter, the ones counter and the bit index.
- LOAD: held for 1 cycle with `puf_fire`=0 so the challenge is stable before launch. Then go to HIGH with `puf_fire` <= 1.
- HIGH: lasts SETTLE+2 cycles.
  - `puf_resp` passes through a 2-flop synchronizer that samples every cycle.
  - In the last HIGH cycle, add the synchronizer output to the ones counter.
  - Then go to LOW with `puf_fire` <= 0.
- LOW: lasts SETTLE cycles to re-arm the arbiter.
  - At its end, if votes done < VOTES, go to HIGH.
  - Otherwise, write `resp_word[bit_idx]` <= (ones > VOTES/2), clear the counters and advance the LFSR.
  - Then go to HIGH if bit_idx < RESP_W-1, else go to DONE.
- LFSR update: Fibonacci, shift left. New bit 0 = c[7]^c[5]^c[4]^c[3] (x^8+x^6+x^5+x^4+1).
  - `challenge` changes only in LOW, never while `puf_fire`=1.
- Response bits fill LSB first.
- DONE: `resp_valid`=1; `resp_word` and `challenge` are held. On `resp_valid`&&`resp_ready`, go to IDLE with `resp_valid` <= 0.
- `start` is ignored whenever `busy`=1, including in DONE.
- Counters are sized $clog2(VOTES+1) and $clog2(RESP_W).

## Timing
- Reset (async assert, sync-free deassert): all outputs are 0 (`challenge`, `puf_fire`, `resp_word`, `resp_valid`, `busy`), the state is IDLE and the synchronizer flops are cleared.
- Reset asserted mid-evaluation drops `puf_fire` immediately. The partial word is discarded.
- Start accepted at edge E0:
  - `busy` and `challenge` update at E0.
  - `puf_fire` first rises at E0+1.
  - `resp_valid` rises at E0+1+RESP_W·VOTES·(2·SETTLE+2). With the defaults this is E0+449.
- Each evaluation is 2·SETTLE+2 cycles: SETTLE+2 HIGH cycles, then SETTLE LOW cycles.
- Handshake:
  - With `resp_ready` held 1 in DONE, `resp_valid` lasts exactly 1 cycle.
  - `busy` falls in the same edge as `resp_valid`.
  - A new `start` can be accepted the next cycle.

## Structure
- Shared package `puf_pkg`:
  - state enum
  - LFSR tap constant 8'hB8 (taps 7,5,4,3)
  - seed-zero substitute value 8'h01
- One sub-module: `puf_lfsr`, holding the load/advance logic and the CHAL_W state register.
- The synchronizer stays inline.

## Test plan
1. PUF stub `puf_resp`=`challenge[0]`, `seed`=8'h01: challenges 01,02,04,08,11,23,47,8E -> `resp_word`=8'h71, `resp_valid` at E0+449.
2. `seed`=8'h00 with the same stub -> identical sequence and `resp_word`=8'h71.
3. Majority:
   - Stub gives 1 on votes 0–3 and 0 on votes 4–6 of every bit -> 8'hFF.
   - Stub gives 1 on votes 0–2 only -> 8'h00.
4. Backpressure: hold `resp_ready`=0 for 20 cycles in DONE, pulsing `start` -> word and `resp_valid` stable, start ignored. Release -> a single accepted transfer, then `busy`=0.
5. Reset while `puf_fire`=1 at vote 3 of bit 4 -> all outputs 0 immediately. A fresh start with `seed`=01 gives 8'h71.
6. Checker throughout: `challenge` never changes while `puf_fire`=1; HIGH and LOW widths are 5 and 3 cycles with the defaults.
